// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the control-signal pipeline: bundle layout and RV32 branch types.
package pipeline_ctrl_pkg;

    // Bit positions of the fields the pipeline itself interprets
    localparam int JUMP_BIT    = 4;
    localparam int JALR_BIT    = 5;
    localparam int BRANCH_BIT  = 6;
    localparam int BR_TYPE_LSB = 7;

    // Full layout of the fixed low 14 bits; anything above bit 13 is spare
    typedef struct packed {
        logic       alu_src;
        logic [2:0] alu_ctrl;
        logic [2:0] br_type;
        logic       branch;
        logic       jalr;
        logic       jump;
        logic [1:0] result_src;
        logic       mem_write;
        logic       reg_write;
    } ctrl_fields_t;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_type_e;

    function automatic logic branch_cond(input logic [2:0] br_type, input logic zero,
                                         input logic lt, input logic ltu);
        logic cond;
        cond = 1'b0;
        case (br_type)
            BR_EQ:   cond = zero;
            BR_NE:   cond = ~zero;
            BR_LT:   cond = lt;
            BR_GE:   cond = ~lt;
            BR_LTU:  cond = ltu;
            BR_GEU:  cond = ~ltu;
            default: cond = 1'b0;
        endcase
        return cond;
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register holding a control bundle and its valid bit.
module ctrl_stage_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         hold,
    input  logic         clear,
    input  logic [W-1:0] next_ctrl,
    input  logic         next_valid,
    output logic [W-1:0] ctrl,
    output logic         valid
);

    // Clear beats hold so a flushed stage never keeps a stale instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl  <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            ctrl  <= '0;
            valid <= 1'b0;
        end else if (!hold) begin
            ctrl  <= next_ctrl;
            valid <= next_valid;
        end
    end

endmodule

// File: rtl/pipeline_ctrl_chain.sv
// Control-bundle pipeline with per-stage stall/flush, branch resolution in a chosen
// execute stage, wrong-path squash and saturating retire/redirect counters.
module pipeline_ctrl_chain #(
    parameter int CTRL_W     = 16,
    parameter int NUM_STAGES = 3,
    parameter int EX_STAGE   = 0,
    parameter int CNT_W      = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CTRL_W-1:0]            ctrl_d,
    input  logic                         valid_d,
    input  logic [NUM_STAGES-1:0]        stall,
    input  logic [NUM_STAGES-1:0]        flush,
    input  logic                         zero_e,
    input  logic                         lt_e,
    input  logic                         ltu_e,
    input  logic                         cnt_clr,
    output logic [NUM_STAGES*CTRL_W-1:0] ctrl_q,
    output logic [NUM_STAGES-1:0]        valid_q,
    output logic                         pc_src_e,
    output logic                         jalr_e,
    output logic [CNT_W-1:0]             retire_count,
    output logic [CNT_W-1:0]             redirect_count
);
    import pipeline_ctrl_pkg::*;

    logic [CTRL_W-1:0]     stage_ctrl [NUM_STAGES];
    logic [NUM_STAGES-1:0] stage_valid;
    logic [NUM_STAGES-1:0] hold;
    logic                  cond_ok;
    logic                  taken;
    logic                  retire_fire;

    // A stall anywhere downstream also freezes every stage behind it
    always_comb begin
        hold = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            hold[i] = |(stall >> i);
        end
    end

    assign cond_ok  = branch_cond(stage_ctrl[EX_STAGE][BR_TYPE_LSB +: 3], zero_e, lt_e, ltu_e);
    assign taken    = stage_valid[EX_STAGE] &
                      (stage_ctrl[EX_STAGE][JUMP_BIT] | stage_ctrl[EX_STAGE][JALR_BIT] |
                       (stage_ctrl[EX_STAGE][BRANCH_BIT] & cond_ok));
    assign pc_src_e = taken & ~hold[EX_STAGE];
    assign jalr_e   = stage_valid[EX_STAGE] & stage_ctrl[EX_STAGE][JALR_BIT];

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        // Stages younger than EX are wrong-path once a redirect fires
        localparam bit SQUASH_CLEAR = (i < EX_STAGE);
        localparam bit SQUASH_LOAD  = (i <= EX_STAGE);

        logic [CTRL_W-1:0] up_ctrl;
        logic              up_valid;
        logic              bubble;

        if (i == 0) begin : g_head
            assign up_ctrl  = ctrl_d;
            assign up_valid = valid_d;
            assign bubble   = SQUASH_LOAD & pc_src_e;
        end else begin : g_body
            assign up_ctrl  = stage_ctrl[i-1];
            assign up_valid = stage_valid[i-1];
            assign bubble   = hold[i-1] | (SQUASH_LOAD & pc_src_e);
        end

        ctrl_stage_reg #(
            .W(CTRL_W)
        ) u_reg (
            .clk        (clk),
            .reset      (reset),
            .hold       (hold[i]),
            .clear      (flush[i] | (SQUASH_CLEAR & pc_src_e)),
            .next_ctrl  (bubble ? '0 : up_ctrl),
            .next_valid (up_valid & ~bubble),
            .ctrl       (stage_ctrl[i]),
            .valid      (stage_valid[i])
        );

        assign ctrl_q[i*CTRL_W +: CTRL_W] = stage_ctrl[i];
    end

    assign valid_q     = stage_valid;
    assign retire_fire = stage_valid[NUM_STAGES-1] & ~hold[NUM_STAGES-1];

    // Counters stick at all-ones; a clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_count   <= '0;
            redirect_count <= '0;
        end else if (cnt_clr) begin
            retire_count   <= '0;
            redirect_count <= '0;
        end else begin
            if (retire_fire && (retire_count != '1)) begin
                retire_count <= retire_count + CNT_W'(1);
            end
            if (pc_src_e && (redirect_count != '1)) begin
                redirect_count <= redirect_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl_chain.sv
// Self-checking bench for pipeline_ctrl_chain: directed scenarios plus a retirement
// scoreboard, with a second instance using 4-bit counters for saturation.
module tb_pipeline_ctrl_chain;
    import pipeline_ctrl_pkg::*;

    localparam int CTRL_W     = 16;
    localparam int NUM_STAGES = 3;
    localparam int EX_STAGE   = 0;
    localparam int CNT_W      = 32;
    localparam int SMALL_W    = 4;

    logic                         clk;
    logic                         reset;
    logic [CTRL_W-1:0]            ctrl_d;
    logic                         valid_d;
    logic [NUM_STAGES-1:0]        stall;
    logic [NUM_STAGES-1:0]        flush;
    logic                         zero_e, lt_e, ltu_e;
    logic                         cnt_clr;
    logic [NUM_STAGES*CTRL_W-1:0] ctrl_q;
    logic [NUM_STAGES-1:0]        valid_q;
    logic                         pc_src_e, jalr_e;
    logic [CNT_W-1:0]             retire_count, redirect_count;
    logic [NUM_STAGES*CTRL_W-1:0] small_ctrl_q;
    logic [NUM_STAGES-1:0]        small_valid_q;
    logic                         small_pc_src_e, small_jalr_e;
    logic [SMALL_W-1:0]           small_retire_count, small_redirect_count;

    int                compared   = 0;
    int                mismatched = 0;
    int                serial     = 0;
    logic [CTRL_W-1:0] expected_q [$];

    pipeline_ctrl_chain #(
        .CTRL_W(CTRL_W), .NUM_STAGES(NUM_STAGES), .EX_STAGE(EX_STAGE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .ctrl_d(ctrl_d), .valid_d(valid_d), .stall(stall),
        .flush(flush), .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e), .cnt_clr(cnt_clr),
        .ctrl_q(ctrl_q), .valid_q(valid_q), .pc_src_e(pc_src_e), .jalr_e(jalr_e),
        .retire_count(retire_count), .redirect_count(redirect_count)
    );

    pipeline_ctrl_chain #(
        .CTRL_W(CTRL_W), .NUM_STAGES(NUM_STAGES), .EX_STAGE(EX_STAGE), .CNT_W(SMALL_W)
    ) dut_small (
        .clk(clk), .reset(reset), .ctrl_d(ctrl_d), .valid_d(valid_d), .stall(stall),
        .flush(flush), .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e), .cnt_clr(cnt_clr),
        .ctrl_q(small_ctrl_q), .valid_q(small_valid_q), .pc_src_e(small_pc_src_e),
        .jalr_e(small_jalr_e), .retire_count(small_retire_count),
        .redirect_count(small_redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [CTRL_W-1:0] mkCtrl(input logic jump, input logic jalr,
                                                 input logic branch, input logic [2:0] br_type,
                                                 input logic [7:0] tag);
        ctrl_fields_t f;
        f            = '0;
        f.reg_write  = 1'b1;
        f.mem_write  = tag[7];
        f.result_src = tag[4:3];
        f.jump       = jump;
        f.jalr       = jalr;
        f.branch     = branch;
        f.br_type    = br_type;
        f.alu_ctrl   = tag[2:0];
        return {tag[6:5], f};
    endfunction

    function automatic logic [CTRL_W-1:0] stageCtrl(input int k);
        return ctrl_q[k*CTRL_W +: CTRL_W];
    endfunction

    // Entries expected to leave the last stage are queued as they are driven
    task automatic applyStimulus(input logic [CTRL_W-1:0] ctrl, input logic valid,
                                 input logic survives);
        ctrl_d  = ctrl;
        valid_d = valid;
        if (valid && survives) expected_q.push_back(ctrl);
    endtask

    // Retirement monitor samples just before each rising edge
    always begin
        @(negedge clk);
        #4;
        if (!reset && valid_q[NUM_STAGES-1] && !stall[NUM_STAGES-1]) begin
            if (expected_q.size() == 0) begin
                checkOutput("retire_unexpected", 64'd1, 64'd0);
            end else begin
                checkOutput("retire_ctrl", stageCtrl(NUM_STAGES-1), expected_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [10:0] sweep [10] = '{
        11'b0_0_1_100_0_0_1_0_0,
        11'b0_0_1_111_1_1_0_1_0,
        11'b0_0_1_110_0_0_1_1_0,
        11'b0_0_1_010_1_1_1_0_0,
        11'b1_0_0_000_0_0_0_1_0,
        11'b1_0_1_011_1_1_1_1_0,
        11'b0_0_1_000_1_0_0_1_0,
        11'b0_0_1_101_0_1_0_0_0,
        11'b0_1_0_000_0_0_0_1_1,
        11'b0_0_1_001_1_0_0_0_0
    };

    initial begin
        logic              s_jump, s_jalr, s_branch, exp_pc, exp_jalr;
        logic [2:0]        s_type;
        logic [CTRL_W-1:0] bne_ctrl;

        reset = 1'b1; ctrl_d = '0; valid_d = 1'b0; stall = '0; flush = '0;
        zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0; cnt_clr = 1'b0;

        @(negedge clk);
        #1;
        checkOutput("reset_valid", valid_q, 0);
        checkOutput("reset_ctrl", ctrl_q, 0);
        checkOutput("reset_retire", retire_count, 0);
        checkOutput("reset_redirect", redirect_count, 0);
        checkOutput("reset_pc_src", pc_src_e, 0);

        // Single entry walks the pipe and retires
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(16'h2A01, 1'b1, 1'b1);
        @(negedge clk); applyStimulus('0, 1'b0, 1'b0); #1;
        checkOutput("t1_valid_e1", valid_q, 3'b001);
        checkOutput("t1_stage0", stageCtrl(0), 16'h2A01);
        @(negedge clk); #1;
        checkOutput("t1_valid_e2", valid_q, 3'b010);
        @(negedge clk); #1;
        checkOutput("t1_valid_e3", valid_q, 3'b100);
        checkOutput("t1_stage2", stageCtrl(2), 16'h2A01);
        checkOutput("t1_retire_e3", retire_count, 0);
        @(negedge clk); #1;
        checkOutput("t1_retire_e4", retire_count, 1);
        checkOutput("t1_valid_e4", valid_q, 3'b000);

        // Taken bne squashes the instruction behind it
        @(negedge clk);
        zero_e   = 1'b0;
        bne_ctrl = mkCtrl(1'b0, 1'b0, 1'b1, BR_NE, 8'(serial++));
        applyStimulus(bne_ctrl, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(mkCtrl(1'b0, 1'b0, 1'b0, 3'b000, 8'(serial++)), 1'b1, 1'b0);
        #1;
        checkOutput("t2_pc_src", pc_src_e, 1);
        checkOutput("t2_jalr", jalr_e, 0);
        checkOutput("t2_redirect_pre", redirect_count, 0);
        @(negedge clk); applyStimulus('0, 1'b0, 1'b0); #1;
        checkOutput("t2_squash_valid", valid_q, 3'b010);
        checkOutput("t2_redirect", redirect_count, 1);
        checkOutput("t2_pc_src_after", pc_src_e, 0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("t2_retire", retire_count, 2);

        // Branch condition sweep, one entry every other cycle
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            {s_jump, s_jalr, s_branch, s_type, zero_e, lt_e, ltu_e, exp_pc, exp_jalr} = sweep[k];
            applyStimulus(mkCtrl(s_jump, s_jalr, s_branch, s_type, 8'(serial++)), 1'b1, 1'b1);
            @(negedge clk); applyStimulus('0, 1'b0, 1'b0); #1;
            checkOutput($sformatf("t3_pc_src_%0d", k), pc_src_e, exp_pc);
            checkOutput($sformatf("t3_jalr_%0d", k), jalr_e, exp_jalr);
        end
        checkOutput("t3_redirect", redirect_count, 7);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("t3_retire", retire_count, 12);

        // stall[1] for two edges holds stages 0-1 and defers the redirect
        @(negedge clk);
        zero_e = 1'b0;
        applyStimulus(mkCtrl(1'b0, 1'b0, 1'b0, 3'b000, 8'(serial++)), 1'b1, 1'b1);
        @(negedge clk);
        bne_ctrl = mkCtrl(1'b0, 1'b0, 1'b1, BR_NE, 8'(serial++));
        applyStimulus(bne_ctrl, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus('0, 1'b0, 1'b0);
        stall = 3'b010;
        #1;
        checkOutput("t4_valid_s0", valid_q, 3'b011);
        checkOutput("t4_pc_src_s0", pc_src_e, 0);
        @(negedge clk); #1;
        checkOutput("t4_valid_s1", valid_q, 3'b011);
        checkOutput("t4_hold_ctrl", stageCtrl(0), bne_ctrl);
        checkOutput("t4_pc_src_s1", pc_src_e, 0);
        @(negedge clk); #1;
        checkOutput("t4_valid_s2", valid_q, 3'b011);
        checkOutput("t4_pc_src_s2", pc_src_e, 0);
        checkOutput("t4_redirect_held", redirect_count, 7);
        stall = 3'b000;
        #1;
        checkOutput("t4_pc_src_release", pc_src_e, 1);
        @(negedge clk); #1;
        checkOutput("t4_redirect", redirect_count, 8);
        checkOutput("t4_valid_after", valid_q, 3'b110);
        checkOutput("t4_pc_src_once", pc_src_e, 0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("t4_retire", retire_count, 14);

        // Flush beats stall on stage 0
        @(negedge clk);
        applyStimulus(mkCtrl(1'b0, 1'b0, 1'b0, 3'b000, 8'(serial++)), 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus('0, 1'b0, 1'b0);
        stall = 3'b001;
        flush = 3'b001;
        #1;
        checkOutput("t5_pre_flush", valid_q, 3'b001);
        @(negedge clk);
        stall = 3'b000;
        flush = 3'b000;
        #1;
        checkOutput("t5_flush_wins", valid_q, 3'b000);

        // Asynchronous reset in the middle of traffic
        @(negedge clk);
        applyStimulus(mkCtrl(1'b0, 1'b0, 1'b0, 3'b000, 8'(serial++)), 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(mkCtrl(1'b1, 1'b0, 1'b0, 3'b000, 8'(serial++)), 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus('0, 1'b0, 1'b0);
        #1;
        checkOutput("t5_inflight", valid_q, 3'b011);
        checkOutput("t5_pc_src_pre", pc_src_e, 1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("t5_rst_valid", valid_q, 0);
        checkOutput("t5_rst_ctrl", ctrl_q, 0);
        checkOutput("t5_rst_pc_src", pc_src_e, 0);
        checkOutput("t5_rst_jalr", jalr_e, 0);
        checkOutput("t5_rst_retire", retire_count, 0);
        checkOutput("t5_rst_redirect", redirect_count, 0);
        @(negedge clk);
        reset = 1'b0;

        // 17 retirements: 4-bit counter saturates
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            applyStimulus(mkCtrl(1'b0, 1'b0, 1'b0, 3'b000, 8'(serial++)), 1'b1, 1'b1);
        end
        @(negedge clk); applyStimulus('0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("t6_retire_wide", retire_count, 17);
        checkOutput("t6_retire_sat", small_retire_count, 15);

        // Clear coincides with a retirement
        @(negedge clk);
        applyStimulus(mkCtrl(1'b0, 1'b0, 1'b0, 3'b000, 8'(serial++)), 1'b1, 1'b1);
        @(negedge clk); applyStimulus('0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        checkOutput("t6_clr_wide", retire_count, 0);
        checkOutput("t6_clr_small", small_retire_count, 0);
        checkOutput("t6_clr_redirect", redirect_count, 0);
        checkOutput("t6_clr_small_redirect", small_redirect_count, 0);
        @(negedge clk);
        applyStimulus(mkCtrl(1'b0, 1'b0, 1'b0, 3'b000, 8'(serial++)), 1'b1, 1'b1);
        @(negedge clk); applyStimulus('0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("t6_after_clr", retire_count, 1);
        checkOutput("t6_after_clr_small", small_retire_count, 1);

        checkOutput("queue_empty", expected_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
